// File: rtl/led_pattern_driver.sv
// LED pattern engine: off / solid / blink / breathe, rendered through a glitch-free PWM
// and driven identically onto every LED pin with a per-pin inversion mask.
module led_pattern_driver #(
    parameter int                   CLK_FREQ    = 32000000,
    parameter int                   STEP_HZ     = 256,
    parameter int                   PWM_BITS    = 8,
    parameter int                   BLINK_STEPS = 128,
    parameter int                   LED_COUNT   = 4,
    parameter logic [LED_COUNT-1:0] LED_INVERT  = '0
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic [1:0]           cfgMode,
    input  logic [PWM_BITS-1:0]  cfgLevel,
    input  logic                 cfgValid,
    output logic                 cfgReady,
    output logic                 stepTick,
    output logic [LED_COUNT-1:0] led
);

    localparam int STEP_DIV = CLK_FREQ / STEP_HZ;
    localparam int PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int BLK_W    = (BLINK_STEPS > 1) ? $clog2(BLINK_STEPS) : 1;

    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [BLK_W-1:0]    BLK_LAST = BLK_W'(BLINK_STEPS - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST = '1;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_SOLID   = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [PRE_W-1:0]     prescaler_q, prescaler_d;
    logic                 cfg_ready_q, cfg_ready_d;
    mode_t                pend_mode_q, pend_mode_d;
    logic [PWM_BITS-1:0]  pend_level_q, pend_level_d;
    mode_t                mode_q, mode_d;
    logic [PWM_BITS-1:0]  level_q, level_d;
    logic [PWM_BITS-1:0]  bright_q, bright_d;
    dir_t                 dir_q, dir_d;
    logic [BLK_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic                 blink_on_q, blink_on_d;
    logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0]  duty_q, duty_d;
    logic [LED_COUNT-1:0] led_q, led_d;

    logic                 tick;
    logic                 accept;
    logic                 apply;
    logic [PWM_BITS-1:0]  target;
    logic                 raw;

    assign tick     = (prescaler_q == PRE_LAST);
    assign stepTick = tick;
    assign cfgReady = cfg_ready_q;
    assign led      = led_q;

    always_comb begin
        prescaler_d  = tick ? '0 : prescaler_q + 1'b1;
        cfg_ready_d  = cfg_ready_q;
        pend_mode_d  = pend_mode_q;
        pend_level_d = pend_level_q;
        mode_d       = mode_q;
        level_d      = level_q;
        bright_d     = bright_q;
        dir_d        = dir_q;
        blink_cnt_d  = blink_cnt_q;
        blink_on_d   = blink_on_q;
        pwm_cnt_d    = pwm_cnt_q + 1'b1;
        duty_d       = duty_q;
        target       = '0;

        // A pending config exists exactly while cfgReady is low, so it is applied on a tick only then.
        accept = cfgValid && cfg_ready_q;
        apply  = tick && !cfg_ready_q;

        if (accept) begin
            pend_mode_d  = mode_t'(cfgMode);
            pend_level_d = cfgLevel;
            cfg_ready_d  = 1'b0;
        end else if (apply) begin
            cfg_ready_d = 1'b1;
        end

        if (apply) begin
            mode_d      = pend_mode_q;
            level_d     = pend_level_q;
            bright_d    = '0;
            dir_d       = DIR_UP;
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (tick) begin
            case (mode_q)
                MODE_BLINK: begin
                    if (blink_cnt_q == BLK_LAST) begin
                        blink_cnt_d = '0;
                        blink_on_d  = !blink_on_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
                MODE_BREATHE: begin
                    // Reversal steps straight to the neighbour value so the peak and floor last one tick.
                    if (dir_q == DIR_UP) begin
                        if (bright_q < level_q) begin
                            bright_d = bright_q + 1'b1;
                        end else begin
                            dir_d    = DIR_DOWN;
                            bright_d = (level_q != '0) ? level_q - 1'b1 : '0;
                        end
                    end else begin
                        if (bright_q != '0) begin
                            bright_d = bright_q - 1'b1;
                        end else begin
                            dir_d    = DIR_UP;
                            bright_d = (level_q != '0) ? PWM_BITS'(1) : '0;
                        end
                    end
                end
                default: ;
            endcase
        end

        case (mode_q)
            MODE_SOLID:   target = level_q;
            MODE_BLINK:   target = blink_on_q ? level_q : '0;
            MODE_BREATHE: target = bright_q;
            default:      target = '0;
        endcase

        if (pwm_cnt_q == PWM_LAST) begin
            duty_d = target;
        end

        raw   = (pwm_cnt_q < duty_q);
        led_d = {LED_COUNT{raw}} ^ LED_INVERT;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            prescaler_q  <= '0;
            cfg_ready_q  <= 1'b1;
            pend_mode_q  <= MODE_OFF;
            pend_level_q <= '0;
            mode_q       <= MODE_OFF;
            level_q      <= '0;
            bright_q     <= '0;
            dir_q        <= DIR_UP;
            blink_cnt_q  <= '0;
            blink_on_q   <= 1'b0;
            pwm_cnt_q    <= '0;
            duty_q       <= '0;
            led_q        <= LED_INVERT;
        end else begin
            prescaler_q  <= prescaler_d;
            cfg_ready_q  <= cfg_ready_d;
            pend_mode_q  <= pend_mode_d;
            pend_level_q <= pend_level_d;
            mode_q       <= mode_d;
            level_q      <= level_d;
            bright_q     <= bright_d;
            dir_q        <= dir_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_on_q   <= blink_on_d;
            pwm_cnt_q    <= pwm_cnt_d;
            duty_q       <= duty_d;
            led_q        <= led_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Bench for led_pattern_driver: directed config sequences with the expected led[0] on-count
// of every PWM period queued up front; a monitor pops one entry per completed period.
module tb_led_pattern_driver;

    logic       clk;
    logic       rst_;
    logic [1:0] cfg_mode;
    logic [3:0] cfg_level;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       step_tick;
    logic [3:0] led;

    int checks   = 0;
    int failures = 0;
    int slot     = 0;
    int win_idx  = 0;
    int acc      = 0;
    int bad      = 0;
    int exp_val  = 0;
    bit tick_prev = 1'b0;
    int exp_q[$];

    int blink_seq[8]    = '{15, 15, 15, 15, 0, 0, 0, 0};
    int breathe_seq[11] = '{15, 0, 1, 2, 3, 2, 1, 0, 1, 2, 3};
    int hshake_seq[3]   = '{7, 10, 10};
    int ramp_seq[4]     = '{0, 1, 2, 3};

    led_pattern_driver #(
        .CLK_FREQ    (1024),
        .STEP_HZ     (64),
        .PWM_BITS    (4),
        .BLINK_STEPS (4),
        .LED_COUNT   (4),
        .LED_INVERT  (4'b1000)
    ) dut (
        .clk      (clk),
        .rst_     (rst_),
        .cfgMode  (cfg_mode),
        .cfgLevel (cfg_level),
        .cfgValid (cfg_valid),
        .cfgReady (cfg_ready),
        .stepTick (step_tick),
        .led      (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Slot n is the falling edge that follows rising edge n after the last reset release.
    task automatic wait_slot(input int target_slot);
        while (slot < target_slot) begin
            @(negedge clk);
            slot++;
        end
    endtask

    task automatic push_exp(input int n, input int value);
        for (int i = 0; i < n; i++) exp_q.push_back(value);
    endtask

    task automatic applyStimulus(input logic [1:0] mode, input logic [3:0] level);
        cfg_mode  = mode;
        cfg_level = level;
        cfg_valid = 1'b1;
        wait_slot(slot + 1);
        cfg_valid = 1'b0;
    endtask

    // A PWM period ends on the sample right after the one that saw stepTick.
    always @(negedge clk) begin
        if (!rst_) begin
            acc       = 0;
            bad       = 0;
            win_idx   = 0;
            tick_prev = 1'b0;
        end else begin
            acc += int'(led[0]);
            if (led != ({4{led[0]}} ^ 4'b1000)) bad++;
            if (tick_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL window%0d_unplanned actual=%0d expected=none", win_idx, acc);
                end else begin
                    exp_val = exp_q.pop_front();
                    checkOutput($sformatf("window%0d_high", win_idx), acc, exp_val);
                end
                checkOutput($sformatf("window%0d_led_mask", win_idx), bad, 0);
                win_idx++;
                acc = 0;
                bad = 0;
            end
            tick_prev = step_tick;
        end
    end

    initial begin
        #60000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_      = 1'b0;
        cfg_valid = 1'b0;
        cfg_mode  = 2'd0;
        cfg_level = 4'd0;
        repeat (3) @(negedge clk);
        #1 rst_ = 1'b1;
        slot = 0;
        push_exp(4, 0);
        #1;
        checkOutput("reset_led", int'(led), 4'b1000);
        checkOutput("reset_ready", int'(cfg_ready), 1);
        checkOutput("reset_tick", int'(step_tick), 0);

        wait_slot(14); checkOutput("tick_before_first", int'(step_tick), 0);
        wait_slot(15); checkOutput("first_tick", int'(step_tick), 1);
        wait_slot(16); checkOutput("tick_one_cycle", int'(step_tick), 0);
        wait_slot(30); checkOutput("tick_gap", int'(step_tick), 0);
        wait_slot(31); checkOutput("tick_period", int'(step_tick), 1);

        // Solid 5: applied at edge 48, seen in PWM periods 4..6.
        wait_slot(32);
        push_exp(3, 5);
        applyStimulus(2'd1, 4'd5);
        checkOutput("ready_drop", int'(cfg_ready), 0);
        wait_slot(47); checkOutput("ready_held", int'(cfg_ready), 0);
        wait_slot(48); checkOutput("ready_after_apply", int'(cfg_ready), 1);

        wait_slot(80);
        foreach (blink_seq[i]) exp_q.push_back(blink_seq[i]);
        applyStimulus(2'd2, 4'd15);

        wait_slot(224);
        foreach (breathe_seq[i]) exp_q.push_back(breathe_seq[i]);
        applyStimulus(2'd3, 4'd3);

        wait_slot(384);
        push_exp(4, 0);
        applyStimulus(2'd3, 4'd0);

        // Transfer on a tick cycle, then a second request held while not ready.
        wait_slot(447);
        checkOutput("hs_tick_cycle", int'(step_tick), 1);
        checkOutput("hs_ready_at_tick", int'(cfg_ready), 1);
        foreach (hshake_seq[i]) exp_q.push_back(hshake_seq[i]);
        cfg_mode  = 2'd1;
        cfg_level = 4'd7;
        cfg_valid = 1'b1;
        wait_slot(448);
        checkOutput("hs_ready_drop", int'(cfg_ready), 0);
        cfg_level = 4'd10;
        wait_slot(463); checkOutput("hs_not_applied_same_tick", int'(cfg_ready), 0);
        wait_slot(464); checkOutput("hs_ready_return", int'(cfg_ready), 1);
        wait_slot(465);
        cfg_valid = 1'b0;
        checkOutput("hs_second_accepted", int'(cfg_ready), 0);
        wait_slot(480); checkOutput("hs_second_applied", int'(cfg_ready), 1);

        wait_slot(496);
        foreach (ramp_seq[i]) exp_q.push_back(ramp_seq[i]);
        applyStimulus(2'd3, 4'd15);

        wait_slot(592);
        applyStimulus(2'd0, 4'd0);
        checkOutput("scoreboard_empty_before_reset", exp_q.size(), 0);
        checkOutput("pending_before_reset", int'(cfg_ready), 0);
        wait_slot(594);
        checkOutput("led_on_before_reset", int'(led), 4'b0111);

        #3 rst_ = 1'b0;
        #1;
        checkOutput("async_reset_led", int'(led), 4'b1000);
        checkOutput("async_reset_ready", int'(cfg_ready), 1);
        checkOutput("async_reset_tick", int'(step_tick), 0);

        repeat (3) @(negedge clk);
        #1 rst_ = 1'b1;
        slot = 0;
        push_exp(3, 0);
        wait_slot(14); checkOutput("tick_before_first_after_reset", int'(step_tick), 0);
        wait_slot(15); checkOutput("first_tick_after_reset", int'(step_tick), 1);
        wait_slot(50);
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
